// File: rtl/xdma_pkg.sv
// Shared types and defaults for the XDMA finish path.
// The finish record is sized for the widest supported dma_id and address;
// users narrow it to their own IdWidth/AddrWidth.
package xdma_pkg;

  localparam int unsigned DefaultTimeoutCycles = 1024;
  localparam int unsigned MaxIdWidth           = 32;
  localparam int unsigned MaxAddrWidth         = 64;

  typedef struct packed {
    logic [MaxIdWidth-1:0]   dma_id;
    logic [MaxAddrWidth-1:0] addr;
  } finish_rec_t;

  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } fin_state_e;

endpackage

// File: rtl/rr_arb_tree.sv
// Round-robin selector: picks the first asserted request at or after
// rr_ptr, wrapping around NumReq. Purely combinational.
module rr_arb_tree #(
  parameter  int unsigned NumReq = 4,
  localparam int unsigned IdxW   = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] req,
  input  logic [IdxW-1:0]   rr_ptr,
  output logic              gnt_valid,
  output logic [IdxW-1:0]   gnt_idx
);

  // Scan requesters starting at the pointer; the first hit wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int unsigned off = 0; off < NumReq; off++) begin
      int unsigned cand;
      cand = (32'(rr_ptr) + off) % NumReq;
      if (!gnt_valid && req[cand[IdxW-1:0]]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand[IdxW-1:0];
      end
    end
  end

endmodule

// File: rtl/xdma_finish_scheduler.sv
// Finish scheduler: arbitrates NumReq finish requesters round-robin into a
// single held finish record with valid/ready output handshake.
// Optional stall watchdog enabled by defining XDMA_FINISH_SCHED_TIMEOUT_EN.
module xdma_finish_scheduler
  import xdma_pkg::*;
#(
  parameter int unsigned NumReq        = 4,
  parameter int unsigned IdWidth       = 8,
  parameter int unsigned AddrWidth     = 48,
  parameter int unsigned TimeoutCycles = DefaultTimeoutCycles
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [NumReq-1:0]                 req_valid_i,
  output logic [NumReq-1:0]                 req_ready_o,
  input  logic [NumReq-1:0][IdWidth-1:0]    req_dma_id_i,
  input  logic [NumReq-1:0][AddrWidth-1:0]  req_addr_i,
  output logic                              finish_valid_o,
  input  logic                              finish_ready_i,
  output logic [IdWidth-1:0]                finish_dma_id_o,
  output logic [AddrWidth-1:0]              finish_addr_o,
  output logic [$clog2(NumReq)-1:0]         finish_src_o,
  output logic                              timeout_o
);

  localparam int unsigned IdxW = $clog2(NumReq);

  if (NumReq < 2 || NumReq > 16) begin : g_bad_numreq
    $error("NumReq must be in 2..16");
  end
  if (IdWidth > MaxIdWidth || AddrWidth > MaxAddrWidth) begin : g_bad_width
    $error("IdWidth/AddrWidth exceed finish_rec_t capacity");
  end

  fin_state_e      state_q, state_d;
  logic [IdxW-1:0] rr_q, rr_d;
  logic [IdxW-1:0] gnt_idx;
  logic [IdxW-1:0] src_q;
  logic            arb_valid;
  logic            handshake;
  logic            load_en;
  finish_rec_t     rec_q, rec_in;
  logic            unused_rec_bits;

  rr_arb_tree #(
    .NumReq (NumReq)
  ) u_arb (
    .req       (req_valid_i),
    .rr_ptr    (rr_q),
    .gnt_valid (arb_valid),
    .gnt_idx   (gnt_idx)
  );

  // A new finish may be loaded whenever the output register is free or is
  // being drained this cycle; reset suppresses any grant.
  assign handshake = (state_q == HOLD) && finish_ready_i;
  assign load_en   = rst_ni && arb_valid && ((state_q == EMPTY) || finish_ready_i);

  // One-hot accept to the granted requester only.
  always_comb begin
    req_ready_o = '0;
    if (load_en) begin
      req_ready_o[gnt_idx] = 1'b1;
    end
  end

  // Widen the granted requester's fields into the shared record type.
  always_comb begin
    rec_in        = '0;
    rec_in.dma_id = MaxIdWidth'(req_dma_id_i[gnt_idx]);
    rec_in.addr   = MaxAddrWidth'(req_addr_i[gnt_idx]);
  end

  // Next state and round-robin pointer.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    case (state_q)
      EMPTY:   if (load_en) state_d = HOLD;
      HOLD:    if (handshake && !load_en) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
    if (load_en) begin
      rr_d = (gnt_idx == IdxW'(NumReq - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // State and pointer registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= EMPTY;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
    end
  end

  // Output register: loads only on a grant, otherwise holds steady.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rec_q <= '0;
      src_q <= '0;
    end else if (load_en) begin
      rec_q <= rec_in;
      src_q <= gnt_idx;
    end
  end

  assign finish_valid_o  = (state_q == HOLD);
  assign finish_dma_id_o = rec_q.dma_id[IdWidth-1:0];
  assign finish_addr_o   = rec_q.addr[AddrWidth-1:0];
  assign finish_src_o    = src_q;

  // Upper record bits are constant zero when narrower widths are configured.
  assign unused_rec_bits = ^rec_q;

`ifdef XDMA_FINISH_SCHED_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TimeoutCycles + 1);

  logic [CntW-1:0] stall_cnt_q;
  logic            timeout_q;

  // Count consecutive stalled HOLD cycles; flag is sticky until reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else if ((state_q == HOLD) && !finish_ready_i) begin
      if (stall_cnt_q != CntW'(TimeoutCycles)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      if (stall_cnt_q >= CntW'(TimeoutCycles - 1)) begin
        timeout_q <= 1'b1;
      end
    end else begin
      stall_cnt_q <= '0;
    end
  end

  assign timeout_o = timeout_q;
`else
  localparam int unsigned unused_timeout_cycles = TimeoutCycles;

  assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_xdma_finish_scheduler.sv
// Self-checking bench for xdma_finish_scheduler (NumReq=4, TimeoutCycles=16).
module tb_xdma_finish_scheduler;

  localparam int N  = 4;
  localparam int IW = 8;
  localparam int AW = 48;
  localparam int TC = 16;

  logic                   clk = 1'b0;
  logic                   rst_ni = 1'b1;
  logic [N-1:0]           req_valid = '0;
  logic [N-1:0]           req_ready;
  logic [N-1:0][IW-1:0]   req_id = '0;
  logic [N-1:0][AW-1:0]   req_addr = '0;
  logic                   fin_valid;
  logic                   fin_ready = 1'b0;
  logic [IW-1:0]          fin_id;
  logic [AW-1:0]          fin_addr;
  logic [1:0]             fin_src;
  logic                   timeout;

  always #5 clk = ~clk;

  xdma_finish_scheduler #(
    .NumReq        (N),
    .IdWidth       (IW),
    .AddrWidth     (AW),
    .TimeoutCycles (TC)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready),
    .req_dma_id_i    (req_id),
    .req_addr_i      (req_addr),
    .finish_valid_o  (fin_valid),
    .finish_ready_i  (fin_ready),
    .finish_dma_id_o (fin_id),
    .finish_addr_o   (fin_addr),
    .finish_src_o    (fin_src),
    .timeout_o       (timeout)
  );

  int n_pass  = 0;
  int n_total = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endfunction

  // Reference model: one optional held finish, a round-robin pointer, and a
  // stall count, all updated from the scheduling rules.
  bit          m_hold;
  logic [IW-1:0] m_id;
  logic [AW-1:0] m_addr;
  int          m_src;
  int          m_rr;
  int          m_stall;
  bit          m_to;

  function automatic bit exp_timeout();
`ifdef XDMA_FINISH_SCHED_TIMEOUT_EN
    return m_to;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    m_hold = 0; m_id = '0; m_addr = '0; m_src = 0;
    m_rr = 0; m_stall = 0; m_to = 0;
  endtask

  // Called mid-cycle (inputs stable): compare, then advance to next cycle.
  task automatic model_step();
    int g;
    logic [N-1:0] exp_rdy;
    g = -1;
    if (!m_hold || fin_ready) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_rr + k) % N;
        if (g < 0 && req_valid[idx]) g = idx;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("m_req_ready", 64'(req_ready), 64'(exp_rdy));
    chk("m_fin_valid", 64'(fin_valid), 64'(m_hold));
    if (m_hold) begin
      chk("m_fin_id",   64'(fin_id),   64'(m_id));
      chk("m_fin_addr", 64'(fin_addr), 64'(m_addr));
      chk("m_fin_src",  64'(fin_src),  64'(m_src));
    end
    chk("m_timeout", 64'(timeout), 64'(exp_timeout()));
    if (m_hold && !fin_ready) begin
      m_stall++;
      if (m_stall >= TC) m_to = 1;
    end else begin
      m_stall = 0;
    end
    if (m_hold && fin_ready) m_hold = 0;
    if (g >= 0) begin
      m_hold = 1; m_id = req_id[g]; m_addr = req_addr[g];
      m_src = g; m_rr = (g + 1) % N;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_valid = '0;
    fin_ready = 1'b0;
    rst_ni    = 1'b0;
    model_reset();
    #3;
    chk("rst_fin_valid", 64'(fin_valid), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_timeout",   64'(timeout),   64'd0);
    chk("rst_fin_id",    64'(fin_id),    64'd0);
    chk("rst_fin_addr",  64'(fin_addr),  64'd0);
    chk("rst_fin_src",   64'(fin_src),   64'd0);
    @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic set_fixed_payload();
    for (int i = 0; i < N; i++) begin
      req_id[i]   = IW'(8'h10 + i);
      req_addr[i] = AW'(48'h1000 * (i + 1));
    end
  endtask

  typedef struct {
    logic [N-1:0] rv;
    logic         rdy;
    logic [N-1:0] exp_rdy;
    logic         exp_fv;
    int           exp_src;
  } vec_t;

  vec_t tbl[10];

  initial begin
    // Directed table, applied from reset (pointer 0).
    tbl[0] = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2}; // single request, ptr -> 3
    tbl[1] = '{4'b1001, 1'b1, 4'b1000, 1'b1, 3}; // wrap: 3 wins, ptr -> 0
    tbl[2] = '{4'b1111, 1'b1, 4'b0001, 1'b1, 0};
    tbl[3] = '{4'b1111, 1'b1, 4'b0010, 1'b1, 1};
    tbl[4] = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2};
    tbl[5] = '{4'b1111, 1'b1, 4'b1000, 1'b1, 3};
    tbl[6] = '{4'b1111, 1'b1, 4'b0001, 1'b1, 0};
    tbl[7] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 0}; // drain to EMPTY
    tbl[8] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 0};
    tbl[9] = '{4'b0010, 1'b0, 4'b0010, 1'b1, 1}; // EMPTY grants without ready

    #2;
    do_reset();
    set_fixed_payload();

    for (int v = 0; v < 10; v++) begin
      req_valid = tbl[v].rv;
      fin_ready = tbl[v].rdy;
      @(negedge clk);
      chk($sformatf("tbl%0d_ready", v), 64'(req_ready), 64'(tbl[v].exp_rdy));
      model_step();
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_fv", v), 64'(fin_valid), 64'(tbl[v].exp_fv));
      if (tbl[v].exp_fv) begin
        chk($sformatf("tbl%0d_src", v), 64'(fin_src), 64'(tbl[v].exp_src));
        chk($sformatf("tbl%0d_id", v), 64'(fin_id), 64'(8'h10 + tbl[v].exp_src));
      end
    end

    // Backpressure: requester 1 held while the output stalls.
    do_reset();
    set_fixed_payload();
    req_valid = 4'b0010;
    fin_ready = 1'b0;
    cycle();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp_ready",  64'(req_ready), 64'd0);
      chk("bp_valid",  64'(fin_valid), 64'd1);
      chk("bp_id",     64'(fin_id),    64'h11);
      chk("bp_addr",   64'(fin_addr),  64'h2000);
      model_step();
      @(posedge clk);
      #1;
    end
    fin_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 64'(req_ready), 64'(4'b0010));
    model_step();
    @(posedge clk);
    #1;
    chk("bp_reload_valid", 64'(fin_valid), 64'd1);
    chk("bp_reload_src",   64'(fin_src),   64'd1);

    // Watchdog: stall a held finish past the limit.
    do_reset();
    set_fixed_payload();
    req_valid = 4'b0001;
    fin_ready = 1'b0;
    cycle();
    req_valid = '0;
    for (int k = 1; k <= 20; k++) begin
      cycle();
`ifdef XDMA_FINISH_SCHED_TIMEOUT_EN
      chk($sformatf("wd_stall%0d", k), 64'(timeout), 64'(k >= TC));
`else
      chk($sformatf("wd_stall%0d", k), 64'(timeout), 64'd0);
`endif
    end
    fin_ready = 1'b1;
    cycle();
    chk("wd_after_hs_valid", 64'(fin_valid), 64'd0);
`ifdef XDMA_FINISH_SCHED_TIMEOUT_EN
    chk("wd_sticky", 64'(timeout), 64'd1);
`else
    chk("wd_sticky", 64'(timeout), 64'd0);
`endif

    // Reset while a finish is held: it must vanish and never reappear.
    do_reset();
    set_fixed_payload();
    req_valid = 4'b0100;
    fin_ready = 1'b0;
    cycle();
    chk("mr_held", 64'(fin_valid), 64'd1);
    #2;
    rst_ni = 1'b0;
    model_reset();
    #1;
    chk("mr_valid_drop", 64'(fin_valid), 64'd0);
    chk("mr_ready_zero", 64'(req_ready), 64'd0);
    req_valid = '0;
    @(negedge clk);
    rst_ni = 1'b1;
    @(posedge clk);
    #1;
    fin_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      cycle();
      chk("mr_no_emit", 64'(fin_valid), 64'd0);
    end

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      req_valid = N'($urandom);
      fin_ready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < N; i++) begin
        req_id[i]   = IW'($urandom);
        req_addr[i] = AW'({$urandom, $urandom});
      end
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/xdma_finish_scheduler.md
XDMA_FINISH_SCHEDULER -- requirements
Module: xdma_finish_scheduler

Interface
REQ-001 SHALL have parameter NumReq, default 4: number of finish requesters; legal range 2..16.
REQ-002 SHALL have parameter IdWidth, default 8: dma_id width.
REQ-003 SHALL have parameter AddrWidth, default 48: remote address width.
REQ-004 SHALL have parameter TimeoutCycles, default 1024: stall watchdog limit.
REQ-005 SHALL have port clk_i, input, 1: clock; all state on rising edge.
REQ-006 SHALL have port rst_ni, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port req_valid_i, input, NumReq: per-requester finish request.
REQ-008 SHALL have port req_ready_o, output, NumReq: per-requester accept.
REQ-009 SHALL have port req_dma_id_i, input, NumReq x IdWidth: per-requester dma_id.
REQ-010 SHALL have port req_addr_i, input, NumReq x AddrWidth: per-requester remote address.
REQ-011 SHALL have port finish_valid_o, output, 1: outgoing finish valid.
REQ-012 SHALL have port finish_ready_i, input, 1: outgoing finish ready.
REQ-013 SHALL have port finish_dma_id_o, output, IdWidth: dma_id of held finish.
REQ-014 SHALL have port finish_addr_o, output, AddrWidth: destination address of held finish.
REQ-015 SHALL have port finish_src_o, output, $clog2(NumReq): index of originating requester.
REQ-016 SHALL have port timeout_o, output, 1: sticky watchdog flag.

Function
REQ-017 SHALL implement a two-state FSM: EMPTY (no finish held) and HOLD (one finish held in the output register).
REQ-018 SHALL, in EMPTY, or in HOLD on the cycle finish_valid_o && finish_ready_i, grant exactly one valid requester by round-robin starting at pointer rr_q.
REQ-019 SHALL assert req_ready_o[i] only for the granted requester, combinationally, in the grant cycle; no other bit.
REQ-020 SHALL capture the granted dma_id, addr and index into the output register on the grant edge; latency request-to-finish_valid_o is one cycle.
REQ-021 SHALL advance rr_q to (granted index + 1) mod NumReq on each grant, wrapping NumReq-1 to 0; rr_q is unchanged when no grant occurs.
REQ-022 SHALL assert finish_valid_o exactly in HOLD and keep all finish_* outputs stable until the handshake.
REQ-023 SHALL go EMPTY->HOLD on a grant, HOLD->EMPTY on a handshake with no valid requester, and stay in HOLD on a handshake plus simultaneous grant, loading the new finish with no bubble.
REQ-024 SHALL guarantee that a continuously asserted requester is granted within NumReq grants.
REQ-025 SHALL treat requests as sticky: a requester deasserting req_valid_i before ready carries no protocol guarantee, and the block SHALL NOT latch it.

Reset
REQ-026 SHALL on rst_ni low set state EMPTY, rr_q=0, output register=0, timeout counter=0; finish_valid_o=0, req_ready_o=0, timeout_o=0.
REQ-027 SHALL drop a finish held at mid-operation reset without emitting it.

Configuration
REQ-028 SHALL, with XDMA_FINISH_SCHED_TIMEOUT_EN defined, count consecutive HOLD cycles without finish_ready_i, reset the count on each handshake, and set timeout_o when the count reaches TimeoutCycles; timeout_o stays set until reset.
REQ-029 SHALL, without XDMA_FINISH_SCHED_TIMEOUT_EN, omit the counter and tie timeout_o to 0.

Structure
REQ-030 SHALL place the finish record struct (dma_id, addr) and the default TimeoutCycles in xdma_pkg.
REQ-031 SHALL instantiate one sub-module rr_arb_tree for round-robin selection; the FSM and output register stay in the top module.

Verification (NumReq=4)
REQ-032 SHALL check single request: req_valid_i=4'b0100, dma_id=0x12, finish_ready_i=1 -> req_ready_o=4'b0100 in the same cycle; next cycle finish_valid_o=1, dma_id_o=0x12, src_o=2; rr_q=3.
REQ-033 SHALL check fairness: req_valid_i=4'b1111 held, ready=1 -> grant order 0,1,2,3,0 with back-to-back finish_valid_o and no bubble.
REQ-034 SHALL check backpressure: ready=0 for 10 cycles with req 1 held -> outputs stable, req_ready_o=0; ready=1 -> handshake, then req 1 granted in the same cycle.
REQ-035 SHALL check wrap: rr_q=3 and req_valid_i=4'b1001 -> requester 3 granted, rr_q=0.
REQ-036 SHALL check reset mid-HOLD: assert rst_ni low while finish_valid_o=1 -> finish_valid_o=0 immediately; the finish never appears after release.
REQ-037 SHALL check the watchdog with the macro defined and TimeoutCycles=16: ready=0 -> timeout_o rises after 16 HOLD cycles and stays 1 after the handshake; with the macro undefined, timeout_o stays 0.
